// File: rtl/controller_mem.sv
// Multi-cycle control FSM for the simple CPU datapath: ALU/MOV, LDR/STR with a req/ack memory handshake, HALT.
// Optional memory timeout: define CTRL_MEM_TIMEOUT_EN to abort memory requests after MEM_TIMEOUT cycles.
module controller_mem #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1),
  parameter int RET_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [1:0]       ALU_op,
  input  logic             mem_ack,
  output logic             waiting,
  output logic [1:0]       reg_sel,
  output logic [1:0]       wb_sel,
  output logic             w_en,
  output logic             en_A,
  output logic             en_B,
  output logic             en_C,
  output logic             en_status,
  output logic             sel_A,
  output logic             sel_B,
  output logic             load_addr,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [RET_W-1:0] retired
);

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    S_WAIT, S_DECODE, S_WR_IMM, S_LD_A, S_LD_B, S_EXE, S_WB, S_CMP,
    S_ADDR, S_LATCH, S_MRD, S_WB_M, S_PASS, S_MWR, S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;
  logic [1:0]       r_alu;
  logic             r_err_illegal;
  logic [RET_W-1:0] r_retired;
  logic             w_illegal;
  logic             w_retire;
  logic             w_to_hit;
  logic             w_movreg;

  // Only MOV reg reaches EXE/WB with opcode MOV, so the opcode alone selects the zero A operand.
  assign w_movreg = (r_op == OP_MOV);

`ifdef CTRL_MEM_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_timeout;
  logic            w_in_mem;

  assign w_in_mem = (r_state == S_MRD) || (r_state == S_MWR);
  // An ack in the final allowed cycle still completes the access.
  assign w_to_hit = w_in_mem && !mem_ack && (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !w_in_mem || mem_ack) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
    if (rst) begin
      r_err_timeout <= 1'b0;
    end else if (w_to_hit) begin
      r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_to_hit    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_WAIT;
      r_err_illegal <= 1'b0;
      r_retired     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_illegal) r_err_illegal <= 1'b1;
      if (w_retire)  r_retired     <= r_retired + RET_W'(1);
    end
  end

  // Instruction fields are captured while in DECODE and then held for the rest of the instruction.
  always_ff @(posedge clk) begin
    if (r_state == S_DECODE) begin
      r_op  <= opcode;
      r_alu <= ALU_op;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_illegal   = 1'b0;
    w_retire    = 1'b0;
    waiting     = 1'b0;
    reg_sel     = 2'b01;
    wb_sel      = 2'b10;
    w_en        = 1'b0;
    en_A        = 1'b0;
    en_B        = 1'b0;
    en_C        = 1'b0;
    en_status   = 1'b0;
    sel_A       = 1'b0;
    sel_B       = 1'b0;
    load_addr   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_WAIT: begin
        waiting = 1'b1;
        if (start) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_state_nxt = S_WAIT;
        case (opcode)
          OP_MOV: begin
            if (ALU_op == 2'b10)      w_state_nxt = S_WR_IMM;
            else if (ALU_op == 2'b00) w_state_nxt = S_LD_B;
            else                      w_illegal   = 1'b1;
          end
          OP_ALU:  w_state_nxt = (ALU_op == 2'b11) ? S_LD_B : S_LD_A;
          OP_LDR, OP_STR: begin
            if (ALU_op == 2'b00) w_state_nxt = S_LD_A;
            else                 w_illegal   = 1'b1;
          end
          OP_HALT: begin
            w_state_nxt = S_HALT;
            w_retire    = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      S_WR_IMM: begin
        reg_sel     = 2'b10;
        w_en        = 1'b1;
        w_retire    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_LD_A: begin
        reg_sel     = 2'b10;
        en_A        = 1'b1;
        w_state_nxt = ((r_op == OP_LDR) || (r_op == OP_STR)) ? S_ADDR : S_LD_B;
      end
      S_LD_B: begin
        reg_sel     = 2'b00;
        en_B        = 1'b1;
        w_state_nxt = ((r_op == OP_ALU) && (r_alu == 2'b01)) ? S_CMP : S_EXE;
      end
      S_EXE: begin
        en_C        = 1'b1;
        sel_A       = w_movreg;
        w_state_nxt = S_WB;
      end
      S_WB: begin
        wb_sel      = 2'b00;
        w_en        = 1'b1;
        sel_A       = w_movreg;
        w_retire    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_CMP: begin
        en_status   = 1'b1;
        w_retire    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_ADDR: begin
        sel_B       = 1'b1;
        en_C        = 1'b1;
        w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        load_addr   = 1'b1;
        // STR also loads the store data (Rd) into B on its way through.
        en_B        = (r_op == OP_STR);
        w_state_nxt = (r_op == OP_LDR) ? S_MRD : S_PASS;
      end
      S_MRD: begin
        mem_req = ~rst;
        if (mem_ack)       w_state_nxt = S_WB_M;
        else if (w_to_hit) w_state_nxt = S_WAIT;
      end
      S_WB_M: begin
        wb_sel      = 2'b01;
        w_en        = 1'b1;
        w_retire    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_PASS: begin
        sel_A       = 1'b1;
        en_C        = 1'b1;
        w_state_nxt = S_MWR;
      end
      S_MWR: begin
        mem_req = ~rst;
        mem_we  = ~rst;
        if (mem_ack) begin
          w_retire    = 1'b1;
          w_state_nxt = S_WAIT;
        end else if (w_to_hit) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  assign err_illegal = r_err_illegal;
  assign retired     = r_retired;

endmodule

// File: tb/tb_controller_mem.sv
// Self-checking bench for controller_mem: vector table, hand-written corner sequences,
// and randomized instructions checked cycle by cycle against a per-instruction step model.
module tb_controller_mem;

  localparam int T  = 4;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst, start, mem_ack;
  logic [2:0]    opcode;
  logic [1:0]    ALU_op;
  logic          waiting, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic          load_addr, mem_req, mem_we, halted, err_illegal, err_timeout;
  logic [1:0]    reg_sel, wb_sel;
  logic [RW-1:0] retired;

  controller_mem #(.MEM_TIMEOUT(T), .RET_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .ALU_op(ALU_op), .mem_ack(mem_ack),
    .waiting(waiting), .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A), .en_B(en_B),
    .en_C(en_C), .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B), .load_addr(load_addr),
    .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .retired(retired)
  );

  always #5 clk = ~clk;

  // {reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B} , {load_addr, mem_req, mem_we, halted, waiting}
  logic [15:0] act;
  assign act = {reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
                load_addr, mem_req, mem_we, halted, waiting};

  localparam logic [15:0] W_WAIT  = {11'b01100000000, 5'b00001};
  localparam logic [15:0] W_DEC   = {11'b01100000000, 5'b00000};
  localparam logic [15:0] W_WRIMM = {11'b10101000000, 5'b00000};
  localparam logic [15:0] W_LDA   = {11'b10100100000, 5'b00000};
  localparam logic [15:0] W_LDB   = {11'b00100010000, 5'b00000};
  localparam logic [15:0] W_CMP   = {11'b01100000100, 5'b00000};
  localparam logic [15:0] W_ADDR  = {11'b01100001001, 5'b00000};
  localparam logic [15:0] W_LATL  = {11'b01100000000, 5'b10000};
  localparam logic [15:0] W_LATS  = {11'b01100010000, 5'b10000};
  localparam logic [15:0] W_MRD   = {11'b01100000000, 5'b01000};
  localparam logic [15:0] W_WBM   = {11'b01011000000, 5'b00000};
  localparam logic [15:0] W_PASS  = {11'b01100001010, 5'b00000};
  localparam logic [15:0] W_MWR   = {11'b01100000000, 5'b01100};
  localparam logic [15:0] W_HALT  = {11'b01100000000, 5'b00010};

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int unsigned ret_m = 0;
  bit ill_m = 1'b0;
  bit to_m  = 1'b0;

  typedef struct { logic [15:0] w; bit mem; bit ack; bit last; } step_t;
  step_t q[$];

  typedef struct { logic [2:0] op; logic [1:0] alu; int k; int lat; int dret; bit ill; } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic push(input logic [15:0] w, input bit mem, input bit ack, input bit last);
    step_t s;
    s.w = w; s.mem = mem; s.ack = ack; s.last = last;
    q.push_back(s);
  endtask

  function automatic logic [15:0] exe_w(input bit sa);
    return {2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, sa, 1'b0, 5'b00000};
  endfunction

  function automatic logic [15:0] wb_w(input bit sa);
    return {2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, sa, 1'b0, 5'b00000};
  endfunction

  // Expected per-cycle outputs of one instruction, from DECODE through the return to WAIT.
  task automatic build(input logic [2:0] op, input logic [1:0] alu, input int k);
    bit ret = 1'b0;
    q.delete();
    push(W_DEC, 0, 0, 0);
    if (op == 3'b110 && alu == 2'b10) begin
      push(W_WRIMM, 0, 0, 0); ret = 1'b1;
    end else if (op == 3'b110 && alu == 2'b00) begin
      push(W_LDB, 0, 0, 0); push(exe_w(1), 0, 0, 0); push(wb_w(1), 0, 0, 0); ret = 1'b1;
    end else if (op == 3'b101) begin
      if (alu != 2'b11) push(W_LDA, 0, 0, 0);
      push(W_LDB, 0, 0, 0);
      if (alu == 2'b01) push(W_CMP, 0, 0, 0);
      else begin push(exe_w(0), 0, 0, 0); push(wb_w(0), 0, 0, 0); end
      ret = 1'b1;
    end else if ((op == 3'b011 || op == 3'b100) && alu == 2'b00) begin
      int n = k;
      bit timed = 1'b0;
      if (TO_EN && k > T) begin n = T; timed = 1'b1; end
      push(W_LDA, 0, 0, 0); push(W_ADDR, 0, 0, 0);
      if (op == 3'b011) push(W_LATL, 0, 0, 0);
      else begin push(W_LATS, 0, 0, 0); push(W_PASS, 0, 0, 0); end
      for (int j = 1; j <= n; j++) push((op == 3'b011) ? W_MRD : W_MWR, 1, (j == k), 0);
      if (timed) to_m = 1'b1;
      else begin
        if (op == 3'b011) push(W_WBM, 0, 0, 0);
        ret = 1'b1;
      end
    end else begin
      ill_m = 1'b1;
    end
    push(W_WAIT, 0, 0, 1);
    if (ret) ret_m++;
  endtask

  task automatic run_random(input logic [2:0] op, input logic [1:0] alu, input int k);
    build(op, alu, k);
    opcode = op; ALU_op = alu; start = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].last) begin
        start = 1'b0; mem_ack = 1'b0;
      end else begin
        start   = 1'($urandom_range(0, 1));
        mem_ack = q[i].mem ? q[i].ack : 1'($urandom_range(0, 1));
        if (i > 0) begin
          opcode = 3'($urandom_range(0, 7));
          ALU_op = 2'($urandom_range(0, 3));
        end
      end
      @(negedge clk);
      check($sformatf("seq op=%b alu=%b k=%0d step%0d", op, alu, k, i), 32'(act), 32'(q[i].w));
      if (!q[i].last) begin @(posedge clk); #1; end
    end
    check("rnd_retired", 32'(retired), 32'(ret_m[RW-1:0]));
    check("rnd_err_illegal", 32'(err_illegal), 32'(ill_m));
    check("rnd_err_timeout", 32'(err_timeout), 32'(to_m));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    ret_m = 0; ill_m = 1'b0; to_m = 1'b0;
  endtask

  initial begin
    int cnt, memcnt, n, r0;
    tbl[0]  = '{3'b110, 2'b10, 0, 2, 1, 1'b0};
    tbl[1]  = '{3'b110, 2'b00, 0, 4, 1, 1'b0};
    tbl[2]  = '{3'b101, 2'b00, 0, 5, 1, 1'b0};
    tbl[3]  = '{3'b101, 2'b10, 0, 5, 1, 1'b0};
    tbl[4]  = '{3'b101, 2'b01, 0, 4, 1, 1'b0};
    tbl[5]  = '{3'b101, 2'b11, 0, 4, 1, 1'b0};
    tbl[6]  = '{3'b011, 2'b00, 3, 8, 1, 1'b0};
    tbl[7]  = '{3'b100, 2'b00, 1, 6, 1, 1'b0};
    tbl[8]  = '{3'b000, 2'b00, 0, 1, 0, 1'b1};
    tbl[9]  = '{3'b110, 2'b01, 0, 1, 0, 1'b1};
    tbl[10] = '{3'b011, 2'b01, 0, 1, 0, 1'b1};
    opcode = 3'b000; ALU_op = 2'b00;

    do_reset();
    @(negedge clk);
    check("reset_outputs", 32'(act), 32'(W_WAIT));
    check("reset_retired", 32'(retired), 32'd0);
    check("reset_errs", 32'({err_illegal, err_timeout}), 32'd0);
    @(posedge clk); #1;

    foreach (tbl[v]) begin
      r0 = retired;
      opcode = tbl[v].op; ALU_op = tbl[v].alu; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cnt = 0; memcnt = 0;
      while (!waiting && cnt < 40) begin
        if (mem_req) begin memcnt++; mem_ack = (memcnt == tbl[v].k); end
        else mem_ack = 1'b0;
        @(posedge clk); #1;
        cnt++;
      end
      mem_ack = 1'b0;
      check($sformatf("tbl%0d_latency", v), 32'(cnt), 32'(tbl[v].lat));
      check($sformatf("tbl%0d_retired", v), 32'(retired - RW'(r0)), 32'(tbl[v].dret));
      check($sformatf("tbl%0d_err_illegal", v), 32'(err_illegal), 32'(tbl[v].ill));
      ret_m += tbl[v].dret;
      if (tbl[v].ill) ill_m = 1'b1;
    end

    // Store with a late (or absent) ack: timeout aborts when enabled, otherwise it waits.
    r0 = retired;
    opcode = 3'b100; ALU_op = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cnt = 0;
    while (!mem_req && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check("mwr_reached", 32'(mem_req), 32'd1);
    n = 0; memcnt = 1;
    while (mem_req && n < 30) begin
      n++;
      if (!mem_we) memcnt = 0;
      mem_ack = (!TO_EN && n == 10);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    check("mwr_req_cycles", 32'(n), TO_EN ? 32'(T) : 32'd10);
    check("mwr_we_held", 32'(memcnt), 32'd1);
    check("mwr_back_wait", 32'(waiting), 32'd1);
    check("mwr_err_timeout", 32'(err_timeout), 32'(TO_EN));
    check("mwr_retired", 32'(retired - RW'(r0)), TO_EN ? 32'd0 : 32'd1);
    if (TO_EN) to_m = 1'b1; else ret_m++;

    for (int i = 0; i < 60; i++) begin
      int kk;
      kk = TO_EN ? $urandom_range(1, T + 2) : $urandom_range(1, 6);
      run_random(3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), kk);
    end

    // Reset in the middle of a load: mem_req drops in the reset cycle itself.
    opcode = 3'b011; ALU_op = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cnt = 0;
    while (!mem_req && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check("mrd_reached", 32'(mem_req), 32'd1);
    rst = 1'b1; #1;
    check("rst_memreq_drop", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_state", 32'(act), 32'(W_WAIT));
    check("rst_mid_clear", 32'({err_illegal, err_timeout, retired}), 32'd0);

    // HALT is absorbing and ignores start; only rst leaves it.
    opcode = 3'b111; ALU_op = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("halt_outputs", 32'(act), 32'(W_HALT));
    check("halt_retired", 32'(retired), 32'd1);
    opcode = 3'b110; ALU_op = 2'b10; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    check("halt_held", 32'(act), 32'(W_HALT));
    check("halt_retired_held", 32'(retired), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("halt_rst_state", 32'(act), 32'(W_WAIT));
    check("halt_rst_retired", 32'(retired), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
